// File: rtl/rf_write_scheduler.sv
// Arbitrates E/W/M producers onto register-file write ports 3 and 4, tracks in-flight M
// destinations for Decode hazard stalls, and forces M through when starved. Optional perf counters: RF_SCHED_PERF_EN.
module rf_write_scheduler #(
    parameter int STARVE_LIMIT   = 8,
    parameter int MAX_M_INFLIGHT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_we,
    input  logic [4:0]  e_rd,
    input  logic [31:0] e_wd,
    input  logic        w_we,
    input  logic [4:0]  w_rd,
    input  logic [31:0] w_wd,
    input  logic        m_valid,
    input  logic [4:0]  m_rd,
    input  logic [31:0] m_wd,
    output logic        m_ready,
    input  logic        d_issue_m,
    input  logic [4:0]  d_rd,
    input  logic [4:0]  d_rs1,
    input  logic [4:0]  d_rs2,
    output logic        d_stall,
    output logic        pipe_hold,
    output logic        RegWE_E,
    output logic [4:0]  A3,
    output logic [31:0] WD3,
    output logic        RegWE_W,
    output logic [4:0]  A4,
    output logic [31:0] WD4
`ifdef RF_SCHED_PERF_EN
    ,
    output logic [31:0] perf_m_wait,
    output logic [31:0] perf_m_drop,
    output logic [31:0] perf_hold
`endif
);

    localparam int IW = $clog2(MAX_M_INFLIGHT + 1);

    logic [31:0]   busy;
    logic [31:0]   busy_nxt;
    logic [IW-1:0] inflight;
    logic [7:0]    starve_cnt;
    logic          hold_q;

    logic e_v, w_req, w_v;
    logic m_drop, m_p3, m_p4, m_acc;
    logic stall, sb_set, sb_dec;

    // NOTE: every variable gets a value before any condition, so no latch is inferred.
    always_comb begin
        e_v    = e_we & (e_rd != 5'd0);
        w_req  = w_we & (w_rd != 5'd0);
        w_v    = w_req & ~(e_v & (w_rd == e_rd));
        // A result whose destination is being written by a newer producer is obsolete.
        m_drop = m_valid & ((m_rd == 5'd0) | (e_v & (m_rd == e_rd)) | (w_req & (m_rd == w_rd)));
        m_p3   = m_valid & ~m_drop & ~e_v;
        m_p4   = m_valid & ~m_drop & e_v & ~w_v;
        m_acc  = m_drop | m_p3 | m_p4;
        stall  = busy[d_rs1] | busy[d_rs2] | busy[d_rd]
               | (d_issue_m & (inflight == IW'(MAX_M_INFLIGHT)));
        sb_set = d_issue_m & ~stall & (d_rd != 5'd0);
        sb_dec = m_valid & m_acc & (inflight != '0);
    end

    always_comb begin
        busy_nxt = busy;
        if (m_valid & m_acc) busy_nxt[m_rd] = 1'b0;
        if (sb_set)          busy_nxt[d_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    assign RegWE_E   = reset & (e_v | m_p3);
    assign A3        = !reset ? 5'd0  : e_v ? e_rd : m_p3 ? m_rd : 5'd0;
    assign WD3       = !reset ? 32'd0 : e_v ? e_wd : m_p3 ? m_wd : 32'd0;
    assign RegWE_W   = reset & (w_v | m_p4);
    assign A4        = !reset ? 5'd0  : w_v ? w_rd : m_p4 ? m_rd : 5'd0;
    assign WD4       = !reset ? 32'd0 : w_v ? w_wd : m_p4 ? m_wd : 32'd0;
    assign m_ready   = reset & m_acc;
    assign d_stall   = reset & stall;
    assign pipe_hold = hold_q;

    // NOTE: busy is a flop vector, not a RAM, so it is cleared by reset like any other state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy       <= '0;
            inflight   <= '0;
            starve_cnt <= '0;
            hold_q     <= 1'b0;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            busy <= busy_nxt;
            if (sb_set & ~sb_dec)
                inflight <= inflight + IW'(1);
            else if (sb_dec & ~sb_set)
                inflight <= inflight - IW'(1);
            hold_q <= (starve_cnt == 8'(STARVE_LIMIT));
            if (m_valid & ~m_acc) begin
                if (starve_cnt != 8'hFF) starve_cnt <= starve_cnt + 8'd1;
            end else begin
                starve_cnt <= '0;
            end
        end
    end

`ifdef RF_SCHED_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_m_wait <= '0;
            perf_m_drop <= '0;
            perf_hold   <= '0;
        end else begin
            if (m_valid & ~m_acc & (perf_m_wait != 32'hFFFF_FFFF)) perf_m_wait <= perf_m_wait + 32'd1;
            if (m_drop & (perf_m_drop != 32'hFFFF_FFFF))          perf_m_drop <= perf_m_drop + 32'd1;
            if (hold_q & (perf_hold != 32'hFFFF_FFFF))            perf_hold   <= perf_hold + 32'd1;
        end
    end
`endif

endmodule
